// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: register address
// width, the in-flight tracker entry layout and the forwarding-window rule.
package hazard_scoreboard_unit_pkg;

   localparam int REG_ADDRESS_LEN = 4;

   // One tracked in-flight instruction (entry0 = EXE, entry1 = MEM, ...)
   typedef struct packed {
      logic                       v;
      logic                       wb_en;
      logic                       mem_read;
      logic [REG_ADDRESS_LEN-1:0] dest;
   } trk_entry_t;

   localparam trk_entry_t TRK_BUBBLE = '0;

   // With forwarding only a load still inside its latency window blocks the
   // consumer; without forwarding any pending write in the tracker does.
   function automatic logic entry_in_window(input int k, input int load_latency,
                                            input logic forward_en, input logic mem_read);
      return forward_en ? ((k < load_latency) & mem_read) : 1'b1;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage hazard scoreboard bus: the ID instruction description and
// pipeline control going in, stall request and statistics coming out.
interface hazard_scoreboard_unit_if #(
   parameter int NUM_SRC    = 3,
   parameter int REG_ADDR_W = 4,
   parameter int CNT_W      = 16
);
   logic                          freeze;
   logic                          flush;
   logic                          id_valid;
   logic [NUM_SRC-1:0]            id_src_valid;
   logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr;
   logic                          id_wb_en;
   logic                          id_mem_read;
   logic [REG_ADDR_W-1:0]         id_dest;
   logic                          ignore_hazard;
   logic                          forward_en;
   logic                          stall_cnt_clr;
   logic                          hazard_detected;
   logic [NUM_SRC-1:0]            hazard_src_mask;
   logic [CNT_W-1:0]              stall_cnt;

   modport master (
      output freeze, flush, id_valid, id_src_valid, id_src_addr, id_wb_en,
             id_mem_read, id_dest, ignore_hazard, forward_en, stall_cnt_clr,
      input  hazard_detected, hazard_src_mask, stall_cnt
   );

   modport slave (
      input  freeze, flush, id_valid, id_src_valid, id_src_addr, id_wb_en,
             id_mem_read, id_dest, ignore_hazard, forward_en, stall_cnt_clr,
      output hazard_detected, hazard_src_mask, stall_cnt
   );
endinterface

// File: rtl/hazard_scoreboard_unit_src_match.sv
// One source operand compared against every tracked in-flight entry.
// Produces a per-entry match vector; the window/mode qualification is
// applied by the top so this block stays purely an address comparator.
module hazard_src_match
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int TRACK_DEPTH = 2,
   parameter int REG_ADDR_W  = REG_ADDRESS_LEN
) (
   input  logic                         src_valid,
   input  logic [REG_ADDR_W-1:0]        src_addr,
   input  trk_entry_t [TRACK_DEPTH-1:0] entries,
   output logic [TRACK_DEPTH-1:0]       match
);

   // Entry k matches when it is live, writes back, and targets this source
   always_comb begin
      match = '0;
      for (int k = 0; k < TRACK_DEPTH; k++) begin
         match[k] = src_valid & entries[k].v & entries[k].wb_en &
                    (entries[k].dest == src_addr);
      end
   end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Load-use / RAW hazard detector beside the ID stage. Keeps a shift register
// of the last TRACK_DEPTH issued instructions, checks every ID source against
// it (with or without forwarding) and counts stall cycles with saturation.
// REG_ADDR_W must equal REG_ADDRESS_LEN, the width of the tracker dest field.
module hazard_scoreboard_unit
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int REG_ADDR_W   = REG_ADDRESS_LEN,
   parameter int NUM_SRC      = 3,
   parameter int TRACK_DEPTH  = 2,
   parameter int LOAD_LATENCY = 1,
   parameter int CNT_W        = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   hazard_scoreboard_unit_if.slave  bus
);

   trk_entry_t [TRACK_DEPTH-1:0]        trk_q, trk_d;
   logic [CNT_W-1:0]                    cnt_q, cnt_d;
   logic [NUM_SRC-1:0][TRACK_DEPTH-1:0] src_match;
   logic [TRACK_DEPTH-1:0]              win;
   logic [NUM_SRC-1:0]                  src_haz;
   logic [NUM_SRC-1:0]                  haz_mask;
   logic                                haz;
   logic                                issue;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      hazard_src_match #(
         .TRACK_DEPTH (TRACK_DEPTH),
         .REG_ADDR_W  (REG_ADDR_W)
      ) u_match (
         .src_valid (bus.id_src_valid[i]),
         .src_addr  (bus.id_src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
         .entries   (trk_q),
         .match     (src_match[i])
      );
   end

   // Which tracker entries count as blocking in the current forwarding mode
   always_comb begin
      win = '0;
      for (int k = 0; k < TRACK_DEPTH; k++) begin
         win[k] = entry_in_window(k, LOAD_LATENCY, bus.forward_en, trk_q[k].mem_read);
      end
   end

   // Per-source hazard, gated by a real, checked, non-flushed ID instruction
   always_comb begin
      src_haz = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src_haz[i] = |(src_match[i] & win);
      end
      haz_mask = src_haz & {NUM_SRC{bus.id_valid & ~bus.ignore_hazard & ~bus.flush}};
      haz      = |haz_mask;
      issue    = bus.id_valid & ~haz & ~bus.flush;
   end

   // Tracker advance: hold on freeze, else shift and load issue or bubble
   always_comb begin
      trk_d = trk_q;
      if (!bus.freeze) begin
         for (int k = TRACK_DEPTH - 1; k >= 1; k--) begin
            trk_d[k] = trk_q[k-1];
         end
         if (issue) begin
            trk_d[0] = '{v: 1'b1, wb_en: bus.id_wb_en, mem_read: bus.id_mem_read,
                         dest: bus.id_dest};
         end else begin
            trk_d[0] = TRK_BUBBLE;
         end
      end
   end

   // Stall counter: clear wins, frozen cycles are not counted, saturates
   always_comb begin
      cnt_d = cnt_q;
      if (bus.stall_cnt_clr) begin
         cnt_d = '0;
      end else if (haz && !bus.freeze && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers; reset empties the tracker so outputs drop at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trk_q <= '0;
         cnt_q <= '0;
      end else begin
         trk_q <= trk_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.hazard_detected = haz;
   assign bus.hazard_src_mask = haz_mask;
   assign bus.stall_cnt       = cnt_q;

endmodule
